cache_mem_arbiter: RTL and testbench

Shared main-memory controller that sits directly downstream of the instruction and data caches. It arbitrates their miss and write-through traffic onto a single word-addressed backing memory with a configurable access latency. Write-throughs are posted into a small FIFO so the data cache never stalls on stores. Read misses are serviced in a fixed priority order and answered with the per-port `busy`/data handshake the caches already speak.

---
 rtl/cache_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shared main-memory controller for the I and D caches: posted write-through FIFO,
// fixed-priority read-miss service and a fixed-latency word-addressed backing store.
module cache_mem_arbiter #(
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_mem_read,
    input  logic [31:0]                   i_mem_address,
    output logic                          i_mem_busy,
    input  logic                          d_mem_read,
    input  logic                          d_mem_write,
    input  logic [31:0]                   d_mem_address,
    input  logic [31:0]                   d_mem_write_data,
    output logic                          d_mem_busy,
    output logic [31:0]                   mem_read_data,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
    output logic                          wr_overflow
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [3:0]    CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(WBUF_DEPTH);
    localparam logic [PW:0]   COUNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OP_WRITE, OP_DREAD, OP_IREAD} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d, sel_op;
    logic            sel_valid;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            enq, deq, fifo_full, perform, mem_we;

    logic [AW-1:0]   fifo_addr_mem [WBUF_DEPTH];
    logic [31:0]     fifo_data_mem [WBUF_DEPTH];
    logic [31:0]     mem_array     [MEM_WORDS];

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{i_mem_address[31:AW], d_mem_address[31:AW]};

    // Pending writes always win so a later read sees every earlier store.
    always_comb begin
        sel_valid = 1'b0;
        sel_op    = OP_WRITE;
        if (state_q == S_IDLE) begin
            if (count_q != '0) begin
                sel_valid = 1'b1;
                sel_op    = OP_WRITE;
            end else if (d_mem_read) begin
                sel_valid = 1'b1;
                sel_op    = OP_DREAD;
            end else if (i_mem_read) begin
                sel_valid = 1'b1;
                sel_op    = OP_IREAD;
            end
        end
    end

    assign deq       = sel_valid && (sel_op == OP_WRITE);
    assign fifo_full = (count_q == FIFO_FULL);
    assign enq       = d_mem_write && (!fifo_full || deq);
    assign perform   = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign mem_we    = perform && (op_q == OP_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (sel_valid) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        d_mem_busy = !((sel_valid && (sel_op == OP_DREAD)) ||
                       ((state_q == S_DONE) && (op_q == OP_DREAD)));
        i_mem_busy = !((sel_valid && (sel_op == OP_IREAD)) ||
                       ((state_q == S_DONE) && (op_q == OP_IREAD)));
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (sel_valid) begin
            cnt_d = CNT_LOAD;
            op_d  = sel_op;
            case (sel_op)
                OP_WRITE: begin
                    addr_d  = fifo_addr_mem[rd_ptr_q];
                    wdata_d = fifo_data_mem[rd_ptr_q];
                end
                OP_DREAD: addr_d = d_mem_address[AW-1:0];
                OP_IREAD: addr_d = i_mem_address[AW-1:0];
                default:  addr_d = addr_q;
            endcase
        end else if ((state_q == S_ACCESS) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (perform && (op_q != OP_WRITE)) begin
            rdata_d = mem_array[addr_q];
        end
    end

    // A full FIFO still accepts a write on the edge its head is dequeued.
    always_comb begin
        ovf_d    = ovf_q | (d_mem_write && fifo_full && !deq);
        wr_ptr_d = enq ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = deq ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            op_q     <= OP_WRITE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_mem[wr_ptr_q] <= d_mem_address[AW-1:0];
            fifo_data_mem[wr_ptr_q] <= d_mem_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

    assign mem_read_data = rdata_q;
    assign wbuf_count    = count_q;
    assign wr_overflow   = ovf_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a queue-based model.
module tb_cache_mem_arbiter;

    localparam int MEM_WORDS  = 1024;
    localparam int LATENCY    = 2;
    localparam int WBUF_DEPTH = 4;
    localparam int CW         = $clog2(WBUF_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_mem_read = 1'b0;
    logic [31:0]   i_mem_address = '0;
    logic          i_mem_busy;
    logic          d_mem_read = 1'b0;
    logic          d_mem_write = 1'b0;
    logic [31:0]   d_mem_address = '0;
    logic [31:0]   d_mem_write_data = '0;
    logic          d_mem_busy;
    logic [31:0]   mem_read_data;
    logic [CW-1:0] wbuf_count;
    logic          wr_overflow;

    int total_checks  = 0;
    int passed_checks = 0;

    cache_mem_arbiter #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY),
        .WBUF_DEPTH(WBUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mem_read      (i_mem_read),
        .i_mem_address   (i_mem_address),
        .i_mem_busy      (i_mem_busy),
        .d_mem_read      (d_mem_read),
        .d_mem_write     (d_mem_write),
        .d_mem_address   (d_mem_address),
        .d_mem_write_data(d_mem_write_data),
        .d_mem_busy      (d_mem_busy),
        .mem_read_data   (mem_read_data),
        .wbuf_count      (wbuf_count),
        .wr_overflow     (wr_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        else
            passed_checks++;
    endtask

    // Drives one cycle of inputs just after the rising edge, returns at the falling edge.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd);
        @(posedge clk);
        #1;
        i_mem_read       = ir;
        i_mem_address    = ia;
        d_mem_read       = dr;
        d_mem_write      = dw;
        d_mem_address    = da;
        d_mem_write_data = dwd;
        @(negedge clk);
    endtask

    task automatic applyReset(input logic val);
        @(posedge clk);
        #1;
        rst_n       = val;
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic readD(input string name, input logic [31:0] addr,
                         input logic [31:0] expected);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, addr, '0);
        checkOutput({name, "_accept"}, {31'b0, d_mem_busy}, 32'd0);
        idle(LATENCY + 1);
        checkOutput({name, "_valid"}, {31'b0, d_mem_busy}, 32'd0);
        checkOutput({name, "_data"}, mem_read_data, expected);
    endtask

    // Reference model: FIFO as queues, memory as an array, and the operation in
    // flight described only by how many cycles ago it was selected (0 = idle).
    logic [31:0] m_mem [MEM_WORDS];
    logic [31:0] m_q_addr [$];
    logic [31:0] m_q_data [$];
    int          m_phase;
    int          m_op;
    int          m_sel;
    int          m_had;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ovf;
    logic        exp_d_busy, exp_i_busy;

    initial begin : model
        m_phase = 0; m_op = 0; m_rdata = '0; m_ovf = 1'b0;
        m_addr = '0; m_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_op    = 0;
                m_rdata = '0;
                m_ovf   = 1'b0;
                m_q_addr.delete();
                m_q_data.delete();
            end
            m_sel = -1;
            if (m_phase == 0) begin
                if (m_q_addr.size() > 0) m_sel = 0;
                else if (d_mem_read)     m_sel = 1;
                else if (i_mem_read)     m_sel = 2;
            end
            exp_d_busy = !((m_sel == 1) || (m_phase == LATENCY + 1 && m_op == 1));
            exp_i_busy = !((m_sel == 2) || (m_phase == LATENCY + 1 && m_op == 2));
            checkOutput("model_d_busy", {31'b0, d_mem_busy}, {31'b0, exp_d_busy});
            checkOutput("model_i_busy", {31'b0, i_mem_busy}, {31'b0, exp_i_busy});
            checkOutput("model_rdata", mem_read_data, m_rdata);
            checkOutput("model_count", 32'(wbuf_count), 32'(m_q_addr.size()));
            checkOutput("model_ovf", {31'b0, wr_overflow}, {31'b0, m_ovf});
            if (rst_n) begin
                m_had = m_q_addr.size();
                if (m_phase == LATENCY) begin
                    if (m_op == 0) m_mem[m_addr] = m_wdata;
                    else           m_rdata = m_mem[m_addr];
                end
                if (m_phase == 0) begin
                    if (m_sel == 0) begin
                        m_addr  = m_q_addr.pop_front();
                        m_wdata = m_q_data.pop_front();
                        m_op    = 0;
                        m_phase = 1;
                    end else if (m_sel == 1) begin
                        m_addr  = d_mem_address & (MEM_WORDS - 1);
                        m_op    = 1;
                        m_phase = 1;
                    end else if (m_sel == 2) begin
                        m_addr  = i_mem_address & (MEM_WORDS - 1);
                        m_op    = 2;
                        m_phase = 1;
                    end
                end else if (m_phase == LATENCY + 1) begin
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
                if (d_mem_write) begin
                    if (m_had < WBUF_DEPTH || m_sel == 0) begin
                        m_q_addr.push_back(d_mem_address & (MEM_WORDS - 1));
                        m_q_data.push_back(d_mem_write_data);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    logic [31:0] ovf_addrs [6];

    initial begin : stimulus
        #1 rst_n = 1'b0;
        applyReset(1'b0);
        checkOutput("reset_count", 32'(wbuf_count), 32'd0);
        checkOutput("reset_ovf", {31'b0, wr_overflow}, 32'd0);
        checkOutput("reset_rdata", mem_read_data, 32'd0);
        checkOutput("reset_d_busy", {31'b0, d_mem_busy}, 32'd1);
        checkOutput("reset_i_busy", {31'b0, i_mem_busy}, 32'd1);
        applyReset(1'b1);
        idle(2);

        // Preload words 0..15, spaced so the FIFO never fills.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'(a),
                          (a == 3) ? 32'h0000_AAAA : 32'hCAFE_0000 + 32'(a));
            idle(3);
        end
        idle(4);

        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, '0, '0);
        checkOutput("iread_c0_busy", {31'b0, i_mem_busy}, 32'd0);
        idle(1);
        checkOutput("iread_c1_busy", {31'b0, i_mem_busy}, 32'd1);
        idle(1);
        checkOutput("iread_c2_busy", {31'b0, i_mem_busy}, 32'd1);
        idle(1);
        checkOutput("iread_c3_busy", {31'b0, i_mem_busy}, 32'd0);
        checkOutput("iread_c3_data", mem_read_data, 32'hCAFE_0005);
        idle(2);

        applyStimulus(1'b1, 32'd9, 1'b1, 1'b0, 32'd7, '0);
        checkOutput("dual_c0_d_busy", {31'b0, d_mem_busy}, 32'd0);
        checkOutput("dual_c0_i_busy", {31'b0, i_mem_busy}, 32'd1);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, '0, '0);
        checkOutput("dual_c3_d_busy", {31'b0, d_mem_busy}, 32'd0);
        checkOutput("dual_c3_i_busy", {31'b0, i_mem_busy}, 32'd1);
        checkOutput("dual_c3_data", mem_read_data, 32'hCAFE_0007);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, '0, '0);
        checkOutput("dual_c4_i_accept", {31'b0, i_mem_busy}, 32'd0);
        idle(3);
        checkOutput("dual_c7_i_busy", {31'b0, i_mem_busy}, 32'd0);
        checkOutput("dual_c7_data", mem_read_data, 32'hCAFE_0009);
        idle(2);

        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'd12, 32'h1234_5678);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd12, '0);
        checkOutput("raw_c1_d_busy", {31'b0, d_mem_busy}, 32'd1);
        checkOutput("raw_c1_count", 32'(wbuf_count), 32'd1);
        for (int c = 2; c <= 4; c++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd12, '0);
        checkOutput("raw_c4_d_busy", {31'b0, d_mem_busy}, 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd12, '0);
        checkOutput("raw_c5_accept", {31'b0, d_mem_busy}, 32'd0);
        idle(3);
        checkOutput("raw_c8_d_busy", {31'b0, d_mem_busy}, 32'd0);
        checkOutput("raw_c8_data", mem_read_data, 32'h1234_5678);
        idle(2);

        // Six back-to-back writes behind an I read: only the last one finds the FIFO full.
        ovf_addrs = '{32'd8, 32'd9, 32'd10, 32'd11, 32'd13, 32'd14};
        applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, '0, '0);
        checkOutput("ovf_c0_i_accept", {31'b0, i_mem_busy}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, ovf_addrs[k], 32'hBEEF_0000 + ovf_addrs[k]);
            if (k == 2) checkOutput("ovf_c3_data", mem_read_data, 32'hCAFE_0002);
        end
        checkOutput("ovf_c6_count", 32'(wbuf_count), 32'd4);
        checkOutput("ovf_c6_flag", {31'b0, wr_overflow}, 32'd0);
        idle(1);
        checkOutput("ovf_c7_flag", {31'b0, wr_overflow}, 32'd1);
        checkOutput("ovf_c7_count", 32'(wbuf_count), 32'd4);
        idle(30);
        readD("ovf_kept13", 32'd13, 32'hBEEF_000D);
        readD("ovf_kept8", 32'd8, 32'hBEEF_0008);
        readD("ovf_dropped14", 32'd14, 32'hCAFE_000E);
        checkOutput("ovf_sticky", {31'b0, wr_overflow}, 32'd1);

        readD("alias_405", 32'h0000_0405, 32'hCAFE_0005);

        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'd3, 32'h5555_5555);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'd4, 32'h4444_4444);
        applyReset(1'b0);
        checkOutput("abort_count", 32'(wbuf_count), 32'd0);
        checkOutput("abort_rdata", mem_read_data, 32'd0);
        checkOutput("abort_ovf", {31'b0, wr_overflow}, 32'd0);
        applyReset(1'b0);
        applyReset(1'b1);
        idle(2);
        readD("abort_mem3", 32'd3, 32'h0000_AAAA);
        readD("abort_mem4", 32'd4, 32'hCAFE_0004);
        idle(2);

        for (int n = 0; n < 2500; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FC0F,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                          $urandom & 32'hFFFF_FC0F, $urandom);
        end
        idle(20);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
